// File: rtl/zrb_at_pkg.sv
// zrb_at_pkg: shared types and constants for the AT command responder.
// It holds the FSM state encoding, the ASCII constants used by the parser,
// the reply string ROM, and the reset values for the baud code and the PIN.
package zrb_at_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISCARD,
    ST_PARSE,
    ST_RESPOND,
    ST_APPLY
  } state_t;

  // Setting that is committed once the reply has been sent
  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_BAUD,
    PEND_PIN
  } pend_t;

  localparam logic [7:0] ASC_A    = 8'h41;
  localparam logic [7:0] ASC_T    = 8'h54;
  localparam logic [7:0] ASC_PLUS = 8'h2B;
  localparam logic [7:0] ASC_B    = 8'h42;
  localparam logic [7:0] ASC_U    = 8'h55;
  localparam logic [7:0] ASC_D    = 8'h44;
  localparam logic [7:0] ASC_P    = 8'h50;
  localparam logic [7:0] ASC_I    = 8'h49;
  localparam logic [7:0] ASC_N    = 8'h4E;
  localparam logic [7:0] ASC_O    = 8'h4F;
  localparam logic [7:0] ASC_K    = 8'h4B;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_1    = 8'h31;
  localparam logic [7:0] ASC_8    = 8'h38;
  localparam logic [7:0] ASC_9    = 8'h39;

  localparam logic [2:0]  BAUD_RST = 3'd3;      // 9600
  localparam logic [15:0] PIN_RST  = 16'h1234;

  // Reply ids: 0 = "OK", 1..8 = "OK<baud>" for codes 0..7, 9 = "OKsetPIN"
  typedef logic [3:0] reply_id_t;
  localparam reply_id_t RID_OK    = 4'd0;
  localparam reply_id_t RID_BAUD0 = 4'd1;
  localparam reply_id_t RID_PIN   = 4'd9;

  // All replies packed back to back; first character sits in the top byte
  typedef logic [5:0] rom_addr_t;
  localparam int ROM_BYTES = 63;
  localparam logic [8*ROM_BYTES-1:0] ROM_STR =
    "OKOK1200OK2400OK4800OK9600OK19200OK38400OK57600OK115200OKsetPIN";

  function automatic rom_addr_t rom_off(reply_id_t id);
    case (id)
      4'd0:    return 6'd0;
      4'd1:    return 6'd2;
      4'd2:    return 6'd8;
      4'd3:    return 6'd14;
      4'd4:    return 6'd20;
      4'd5:    return 6'd26;
      4'd6:    return 6'd33;
      4'd7:    return 6'd40;
      4'd8:    return 6'd47;
      4'd9:    return 6'd55;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [3:0] rom_len(reply_id_t id);
    case (id)
      4'd0:                      return 4'd2;
      4'd1, 4'd2, 4'd3, 4'd4:    return 4'd6;
      4'd5, 4'd6, 4'd7:          return 4'd7;
      4'd8, 4'd9:                return 4'd8;
      default:                   return 4'd2;
    endcase
  endfunction

  function automatic logic [7:0] rom_byte(rom_addr_t a);
    if (int'(a) >= ROM_BYTES) return 8'h00;
    return ROM_STR[8*(ROM_BYTES-1-int'(a)) +: 8];
  endfunction

  function automatic logic is_digit(logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

endpackage

// File: rtl/zrb_at_responder_if.sv
// zrb_at_responder_if: byte links around the responder -- received bytes
// from the UART receiver and reply bytes towards the TX FIFO.
interface zrb_at_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_full;
  logic       tx_wr;
  logic [7:0] tx_data;

  // Side that supplies received bytes and owns the TX FIFO
  modport master (
    output rx_data, rx_valid, tx_full,
    input  tx_wr, tx_data
  );

  // The responder itself
  modport slave (
    input  rx_data, rx_valid, tx_full,
    output tx_wr, tx_data
  );
endinterface

// File: rtl/zrb_at_str_sender.sv
// zrb_at_str_sender: streams one reply string from the ROM into the TX FIFO.
// The byte is emitted in the same cycle as start when the FIFO has room, so
// the first write appears one cycle after the parser decides. A full FIFO
// holds the current index; done pulses together with the last write.
module zrb_at_str_sender
  import zrb_at_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  reply_id_t  reply_id,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       done
);

  logic       active_q, active_d;
  rom_addr_t  ptr_q, ptr_d;
  rom_addr_t  last_q, last_d;
  logic       tx_wr_q, tx_wr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       done_q, done_d;

  logic       cur_active;
  rom_addr_t  cur_ptr;
  rom_addr_t  cur_last;

  // Pick the next ROM byte and advance unless the FIFO is full
  always_comb begin
    cur_active = start | active_q;
    cur_ptr    = start ? rom_off(reply_id) : ptr_q;
    cur_last   = start ? rom_addr_t'(rom_off(reply_id) + {2'b00, rom_len(reply_id)} - 6'd1)
                       : last_q;

    active_d  = cur_active;
    ptr_d     = cur_ptr;
    last_d    = cur_last;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;

    if (cur_active && !tx_full) begin
      tx_wr_d   = 1'b1;
      tx_data_d = rom_byte(cur_ptr);
      ptr_d     = cur_ptr + 6'd1;
      if (cur_ptr == cur_last) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // Sender state and registered FIFO outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      ptr_q     <= '0;
      last_q    <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  assign tx_wr   = tx_wr_q;
  assign tx_data = tx_data_q;
  assign done    = done_q;

endmodule

// File: rtl/zrb_at_responder.sv
// zrb_at_responder: emulates the responder side of an HC-06 style AT link.
// Commands are framed by GAP_TICKS clk_en ticks of silence, matched exactly
// ("AT", "AT+BAUDn", and "AT+PINdddd" when ZRB_AT_PIN_EN is defined), the
// ASCII reply is written to the TX FIFO, and only then is the new baud code
// or PIN committed so the reply still goes out at the old rate.
// Without ZRB_AT_PIN_EN the PIN command is rejected and pin is constant.
module zrb_at_responder
  import zrb_at_pkg::*;
#(
  parameter int GAP_TICKS = 64,
  parameter int MAX_LEN   = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  zrb_at_responder_if.slave   bus,
  output logic [2:0]          baud_code,
  output logic                baud_update,
  output logic [15:0]         pin,
  output logic                busy,
  output logic                cmd_err
);

  // Buffer is at least as deep as the longest command the parser inspects
  localparam int BUF_D = (MAX_LEN < 10) ? 10 : MAX_LEN;
  localparam int LEN_W = $clog2(BUF_D + 1);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [2:0]        baud_code_q, baud_code_d;
  logic              baud_update_q, baud_update_d;
  logic              busy_q, busy_d;
  logic              cmd_err_q, cmd_err_d;
  pend_t             pend_q, pend_d;
  logic [2:0]        pend_baud_q, pend_baud_d;
`ifdef ZRB_AT_PIN_EN
  logic [15:0]       pin_q, pin_d;
  logic [15:0]       pend_pin_q, pend_pin_d;
  logic              is_pin;
`endif

  logic [7:0]        cmd_q [BUF_D];
  logic              buf_we;
  logic [LEN_W-1:0]  buf_wa;

  logic              is_at;
  logic              is_baud;
  logic [2:0]        baud_sel;
  logic              gap_hit;

  logic              snd_start;
  reply_id_t         snd_id;
  logic              snd_wr;
  logic [7:0]        snd_data;
  logic              snd_done;

  // Exact-match decode of the buffered command
  always_comb begin
    is_at = (len_q == LEN_W'(2)) && (cmd_q[0] == ASC_A) && (cmd_q[1] == ASC_T);

    is_baud = (len_q == LEN_W'(8)) &&
              (cmd_q[0] == ASC_A) && (cmd_q[1] == ASC_T) && (cmd_q[2] == ASC_PLUS) &&
              (cmd_q[3] == ASC_B) && (cmd_q[4] == ASC_A) && (cmd_q[5] == ASC_U) &&
              (cmd_q[6] == ASC_D) && (cmd_q[7] >= ASC_1) && (cmd_q[7] <= ASC_8);
    baud_sel = 3'(cmd_q[7] - ASC_1);

`ifdef ZRB_AT_PIN_EN
    is_pin = (len_q == LEN_W'(10)) &&
             (cmd_q[0] == ASC_A) && (cmd_q[1] == ASC_T) && (cmd_q[2] == ASC_PLUS) &&
             (cmd_q[3] == ASC_P) && (cmd_q[4] == ASC_I) && (cmd_q[5] == ASC_N) &&
             is_digit(cmd_q[6]) && is_digit(cmd_q[7]) &&
             is_digit(cmd_q[8]) && is_digit(cmd_q[9]);
`endif
  end

  // Next-state logic: framing, parsing, reply sequencing and commit
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    gap_d         = gap_q;
    baud_code_d   = baud_code_q;
    baud_update_d = 1'b0;
    cmd_err_d     = 1'b0;
    pend_d        = pend_q;
    pend_baud_d   = pend_baud_q;
`ifdef ZRB_AT_PIN_EN
    pin_d         = pin_q;
    pend_pin_d    = pend_pin_q;
`endif
    buf_we        = 1'b0;
    buf_wa        = len_q;
    snd_start     = 1'b0;
    snd_id        = RID_OK;
    gap_hit       = clk_en && (gap_q == GAP_W'(GAP_TICKS - 1));

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          buf_we  = 1'b1;
          buf_wa  = '0;
          len_d   = LEN_W'(1);
          gap_d   = '0;
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (bus.rx_valid) begin
          gap_d = '0;
          if (len_q == LEN_W'(MAX_LEN)) begin
            cmd_err_d = 1'b1;
            state_d   = ST_DISCARD;
          end else begin
            buf_we = 1'b1;
            len_d  = len_q + LEN_W'(1);
          end
        end else if (clk_en) begin
          if (gap_hit) begin
            gap_d   = '0;
            state_d = ST_PARSE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      ST_DISCARD: begin
        if (bus.rx_valid) begin
          gap_d = '0;
        end else if (clk_en) begin
          if (gap_hit) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      ST_PARSE: begin
        if (is_at) begin
          snd_start = 1'b1;
          snd_id    = RID_OK;
          pend_d    = PEND_NONE;
          state_d   = ST_RESPOND;
        end else if (is_baud) begin
          snd_start   = 1'b1;
          snd_id      = RID_BAUD0 + {1'b0, baud_sel};
          pend_d      = PEND_BAUD;
          pend_baud_d = baud_sel;
          state_d     = ST_RESPOND;
`ifdef ZRB_AT_PIN_EN
        end else if (is_pin) begin
          snd_start  = 1'b1;
          snd_id     = RID_PIN;
          pend_d     = PEND_PIN;
          pend_pin_d = {cmd_q[6][3:0], cmd_q[7][3:0], cmd_q[8][3:0], cmd_q[9][3:0]};
          state_d    = ST_RESPOND;
`endif
        end else begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      // Commit on the edge after the last write so the new value is
      // visible exactly one cycle after it
      ST_RESPOND: begin
        if (snd_done) begin
          state_d = ST_APPLY;
          case (pend_q)
            PEND_BAUD: begin
              baud_code_d   = pend_baud_q;
              baud_update_d = 1'b1;
            end
`ifdef ZRB_AT_PIN_EN
            PEND_PIN: pin_d = pend_pin_q;
`endif
            default: ;
          endcase
        end
      end

      ST_APPLY: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Main FSM and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      gap_q         <= '0;
      baud_code_q   <= BAUD_RST;
      baud_update_q <= 1'b0;
      busy_q        <= 1'b0;
      cmd_err_q     <= 1'b0;
      pend_q        <= PEND_NONE;
      pend_baud_q   <= BAUD_RST;
`ifdef ZRB_AT_PIN_EN
      pin_q         <= PIN_RST;
      pend_pin_q    <= PIN_RST;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      baud_code_q   <= baud_code_d;
      baud_update_q <= baud_update_d;
      busy_q        <= busy_d;
      cmd_err_q     <= cmd_err_d;
      pend_q        <= pend_d;
      pend_baud_q   <= pend_baud_d;
`ifdef ZRB_AT_PIN_EN
      pin_q         <= pin_d;
      pend_pin_q    <= pend_pin_d;
`endif
    end
  end

  // Command byte buffer; contents are only meaningful up to len_q
  always_ff @(posedge clk) begin
    if (buf_we) cmd_q[buf_wa] <= bus.rx_data;
  end

  zrb_at_str_sender u_sender (
    .clk      (clk),
    .reset    (reset),
    .start    (snd_start),
    .reply_id (snd_id),
    .tx_full  (bus.tx_full),
    .tx_wr    (snd_wr),
    .tx_data  (snd_data),
    .done     (snd_done)
  );

  assign bus.tx_wr   = snd_wr;
  assign bus.tx_data = snd_data;
  assign baud_code   = baud_code_q;
  assign baud_update = baud_update_q;
  assign busy        = busy_q;
  assign cmd_err     = cmd_err_q;
`ifdef ZRB_AT_PIN_EN
  assign pin         = pin_q;
`else
  assign pin         = PIN_RST;
`endif

endmodule

// File: tb/tb_zrb_at_responder.sv
// tb_zrb_at_responder: directed checks of framing, parsing, replies,
// backpressure, commit timing and mid-reply reset of zrb_at_responder.
module tb_zrb_at_responder;
  localparam int GAP = 4;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic [2:0]  baud_code;
  logic        baud_update;
  logic [15:0] pin;
  logic        busy;
  logic        cmd_err;

  zrb_at_responder_if bus ();

  zrb_at_responder #(.GAP_TICKS(GAP), .MAX_LEN(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .bus         (bus),
    .baud_code   (baud_code),
    .baud_update (baud_update),
    .pin         (pin),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor state, sampled on the falling edge
  int          cyc = 0;
  logic [7:0]  q[$];
  int          nwr, first_wr, last_wr, bu_cnt, bu_cyc, err_cnt, pin_chg_cyc, stall_viol;
  logic        full_prev = 1'b0;
  logic [15:0] pin_prev  = 16'h1234;

  always @(negedge clk) begin
    cyc++;
    if (bus.tx_wr === 1'b1) begin
      if (nwr == 0) first_wr = cyc;
      last_wr = cyc;
      nwr++;
      q.push_back(bus.tx_data);
      if (full_prev) stall_viol++;
    end
    if (baud_update === 1'b1) begin
      bu_cnt++;
      bu_cyc = cyc;
    end
    if (cmd_err === 1'b1) err_cnt++;
    if (pin !== pin_prev) pin_chg_cyc = cyc;
    pin_prev  = pin;
    full_prev = bus.tx_full;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr();
    q.delete();
    nwr = 0; first_wr = -1; last_wr = -1;
    bu_cnt = 0; bu_cyc = -1; err_cnt = 0; pin_chg_cyc = -1; stall_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (busy === 1'b0) break;
      tick(1);
    end
    chk({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    tick(3);
  endtask

  task automatic chk_reply(input string tag, input string exp, input bit contiguous);
    chk({tag, "_nwr"}, nwr, exp.len());
    for (int i = 0; i < exp.len(); i++)
      if (i < q.size()) chk({tag, "_byte"}, {24'd0, q[i]}, {24'd0, exp[i]});
    if (contiguous) chk({tag, "_contiguous"}, last_wr - first_wr, exp.len() - 1);
  endtask

  task automatic report(input string name);
    $display("txn %s: writes=%0d baud=%0d pin=%h cmd_err_pulses=%0d",
             name, nwr, baud_code, pin, err_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int n_seen;
  int nwr_hold;

  initial begin
    reset = 1'b1; clk_en = 1'b1;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_full = 1'b0;
    clr();
    tick(3);
    // Reset values
    chk("rst_tx_wr", {31'd0, bus.tx_wr}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
    chk("rst_baud", {29'd0, baud_code}, 32'd3);
    chk("rst_bu", {31'd0, baud_update}, 32'd0);
    chk("rst_pin", {16'd0, pin}, 32'h1234);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, cmd_err}, 32'd0);
    reset = 1'b0;
    tick(2);
    report("reset");

    // Plain AT
    clr();
    send_str("AT");
    wait_idle("at");
    chk_reply("at", "OK", 1'b1);
    chk("at_baud", {29'd0, baud_code}, 32'd3);
    chk("at_err", err_cnt, 0);
    chk("at_bu", bu_cnt, 0);
    report("AT");

    // Baud change to 115200
    clr();
    send_str("AT+BAUD8");
    wait_idle("b8");
    chk_reply("b8", "OK115200", 1'b1);
    chk("b8_bu_cnt", bu_cnt, 1);
    chk("b8_bu_time", bu_cyc, last_wr + 1);
    chk("b8_baud", {29'd0, baud_code}, 32'd7);
    chk("b8_err", err_cnt, 0);
    report("AT+BAUD8");

    // Out-of-range baud digit is rejected
    clr();
    send_str("AT+BAUD9");
    wait_idle("b9");
    chk("b9_err", err_cnt, 1);
    chk("b9_nwr", nwr, 0);
    chk("b9_baud", {29'd0, baud_code}, 32'd7);
    report("AT+BAUD9");

    // PIN command
    clr();
    send_str("AT+PIN0042");
    wait_idle("pin");
`ifdef ZRB_AT_PIN_EN
    chk_reply("pin", "OKsetPIN", 1'b1);
    chk("pin_val", {16'd0, pin}, 32'h0042);
    chk("pin_time", pin_chg_cyc, last_wr + 1);
    chk("pin_err", err_cnt, 0);
`else
    chk("pin_err", err_cnt, 1);
    chk("pin_nwr", nwr, 0);
    chk("pin_val", {16'd0, pin}, 32'h1234);
`endif
    chk("pin_bu", bu_cnt, 0);
    report("AT+PIN0042");

    // Overlong command: 12 back-to-back bytes
    clr();
    begin
      string s;
      s = "AT+BAUD12345";
      for (int i = 0; i < 12; i++) begin
        bus.rx_data  = s[i];
        bus.rx_valid = 1'b1;
        tick(1);
        if (i == 9)  chk("long_err_b10", {31'd0, cmd_err}, 32'd0);
        if (i == 10) chk("long_err_b11", {31'd0, cmd_err}, 32'd1);
      end
      bus.rx_valid = 1'b0;
    end
    wait_idle("long");
    chk("long_err_cnt", err_cnt, 1);
    chk("long_nwr", nwr, 0);
    report("overlong");

    clr();
    send_str("AT");
    wait_idle("at2");
    chk_reply("at2", "OK", 1'b1);
    report("AT after overlong");

    // Baud back to 115200, then reset after the third reply byte
    clr();
    send_str("AT+BAUD8");
    wait_idle("b8b");
    chk("b8b_baud", {29'd0, baud_code}, 32'd7);
    clr();
    send_str("AT+BAUD8");
    n_seen = 0;
    for (int i = 0; i < 100 && n_seen < 3; i++) begin
      tick(1);
      if (bus.tx_wr === 1'b1) n_seen++;
    end
    chk("rmid_third_write", n_seen, 3);
    reset = 1'b1;
    #1;
    chk("rmid_tx_wr", {31'd0, bus.tx_wr}, 32'd0);
    chk("rmid_baud", {29'd0, baud_code}, 32'd3);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_pin", {16'd0, pin}, 32'h1234);
    tick(2);
    reset = 1'b0;
    nwr_hold = nwr;
    tick(20);
    chk("rmid_no_more_writes", nwr, nwr_hold);
    chk("rmid_bu", bu_cnt, 0);
    report("reset mid-reply");

    // AT+BAUD4 with the TX FIFO full across PARSE
    clr();
    send_str("AT+BAUD4");
    bus.tx_full = 1'b1;
    tick(GAP + 8);
    chk("stall_nwr", nwr, 0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    bus.tx_full = 1'b0;
    wait_idle("b4");
    chk_reply("b4", "OK9600", 1'b1);
    chk("b4_stall_viol", stall_viol, 0);
    chk("b4_bu_cnt", bu_cnt, 1);
    chk("b4_bu_time", bu_cyc, last_wr + 1);
    chk("b4_baud", {29'd0, baud_code}, 32'd3);
    report("AT+BAUD4 stalled");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
